// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// Contents: multiply-timer state encoding, default widths/latency and the x0 register index.
package pipe_ctrl_pkg;

  // Multiply timer states: StRun = 1'b0, StMulWait = 1'b1.
  typedef enum logic {
    StRun     = 1'b0,
    StMulWait = 1'b1
  } mul_state_e;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned MUL_LAT_DEF    = 2;
  localparam int unsigned CNT_W_DEF      = 4;

  // Index of the hard-wired zero register.
  localparam int unsigned X0_IDX = 0;

endpackage

// File: rtl/haz_mul_timer.sv
// Multiply residency timer for the EX stage.
// Owns the only controller state: the RUN/MUL_WAIT state and the countdown counter.
// Ports:
//   clk, arst_n  - clock, asynchronous active-low reset
//   idex_mul     - instruction in EX is a multiply
//   redirect     - branch/jump redirect in MEM; aborts any multiply in flight
//   mul_stall    - hold PC/IF/ID/ID-EX and bubble EX/MEM this cycle
//   mul_release  - final multiply cycle; result is captured into EX/MEM
module haz_mul_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic arst_n,
  input  logic idex_mul,
  input  logic redirect,
  output logic mul_stall,
  output logic mul_release
);

  // Entry cycle plus LoadVal+1 wait cycles gives exactly MUL_LAT cycles in EX.
  localparam bit          MulStalls = (MUL_LAT > 1);
  localparam int unsigned LoadInt   = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] LoadVal = LoadInt[CNT_W-1:0];

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_stall   = 1'b0;
    mul_release = 1'b0;
    if (redirect) begin
      // The multiply is younger than the branch, so it is simply dropped.
      state_d = StRun;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StRun: begin
          if (idex_mul && MulStalls) begin
            mul_stall = 1'b1;
            state_d   = StMulWait;
            cnt_d     = LoadVal;
          end
        end
        StMulWait: begin
          if (cnt_q != '0) begin
            mul_stall = 1'b1;
            cnt_d     = cnt_q - 1'b1;
          end else begin
            mul_release = 1'b1;
            state_d     = StRun;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Drives enables and synchronous flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Priority: redirect > multiply > load-use. Outputs are combinational from the
// timer state and the current hazard inputs; all outputs are 0 while arst_n=0.
// Ports:
//   clk, arst_n                      - clock, asynchronous active-low reset
//   id_valid/id_rs1/id_rs2/id_use_*  - instruction in ID and its source usage
//   idex_memread/idex_rd/idex_mul    - instruction in EX
//   exmem_redirect                   - taken branch or jump resolved in MEM
//   *_en, *_flush                    - pipeline register controls
//   mul_busy                         - multiply stall in progress
// Build option: define HAZ_PERF_CNT_EN to add the stall_cycles and flush_events
// saturating performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT    = MUL_LAT_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_mul,
  input  logic                  exmem_redirect,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  mul_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  localparam logic [REG_ADDR_W-1:0] X0 = X0_IDX[REG_ADDR_W-1:0];

  logic mul_stall, mul_release;
  logic lu_hit, lu_stall;

  haz_mul_timer #(
    .MUL_LAT (MUL_LAT),
    .CNT_W   (CNT_W)
  ) u_mul_timer (
    .clk         (clk),
    .arst_n      (arst_n),
    .idex_mul    (idex_mul),
    .redirect    (exmem_redirect),
    .mul_stall   (mul_stall),
    .mul_release (mul_release)
  );

  always_comb begin
    lu_hit = id_valid && idex_memread && (idex_rd != X0) &&
             ((id_use_rs1 && (id_rs1 == idex_rd)) || (id_use_rs2 && (id_rs2 == idex_rd)));
    // Load-use only in RUN with nothing of higher priority; a multiply flag in EX wins even
    // when the multiply itself needs no stall.
    lu_stall = lu_hit && !exmem_redirect && !idex_mul && !mul_stall && !mul_release;

    pc_en       = arst_n && !mul_stall && !lu_stall;
    ifid_en     = arst_n && !mul_stall && !lu_stall;
    idex_en     = arst_n && !mul_stall;
    exmem_en    = arst_n;
    memwb_en    = arst_n;
    ifid_flush  = arst_n && exmem_redirect;
    idex_flush  = arst_n && (exmem_redirect || lu_stall);
    exmem_flush = arst_n && (exmem_redirect || mul_stall);
    mul_busy    = arst_n && mul_stall;
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (exmem_redirect && (flush_events != '1)) begin
        flush_events <= flush_events + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  // Output vector order: pc, ifid, idex, exmem, memwb en; ifid, idex, exmem flush; mul_busy.
  localparam logic [8:0] VRst  = 9'b000000000;
  localparam logic [8:0] VRun  = 9'b111110000;
  localparam logic [8:0] VMul  = 9'b000110011;
  localparam logic [8:0] VLu   = 9'b001110100;
  localparam logic [8:0] VRdr  = 9'b111111110;

  typedef struct {
    string      nm;
    logic [8:0] e4;
    logic [8:0] e1;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, idex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       idex_memread = 1'b0, idex_mul = 1'b0, exmem_redirect = 1'b0;

  logic [8:0] o4, o1;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] sc4, fe4, sc1, fe1;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(4), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .clk (clk), .arst_n (arst_n), .id_valid (id_valid), .id_rs1 (id_rs1), .id_rs2 (id_rs2),
    .id_use_rs1 (id_use_rs1), .id_use_rs2 (id_use_rs2), .idex_memread (idex_memread),
    .idex_rd (idex_rd), .idex_mul (idex_mul), .exmem_redirect (exmem_redirect),
    .pc_en (o4[8]), .ifid_en (o4[7]), .idex_en (o4[6]), .exmem_en (o4[5]), .memwb_en (o4[4]),
    .ifid_flush (o4[3]), .idex_flush (o4[2]), .exmem_flush (o4[1]), .mul_busy (o4[0])
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles (sc4), .flush_events (fe4)
`endif
  );

  pipe_hazard_ctrl #(.MUL_LAT(1), .REG_ADDR_W(5), .CNT_W(4)) dut1 (
    .clk (clk), .arst_n (arst_n), .id_valid (id_valid), .id_rs1 (id_rs1), .id_rs2 (id_rs2),
    .id_use_rs1 (id_use_rs1), .id_use_rs2 (id_use_rs2), .idex_memread (idex_memread),
    .idex_rd (idex_rd), .idex_mul (idex_mul), .exmem_redirect (exmem_redirect),
    .pc_en (o1[8]), .ifid_en (o1[7]), .idex_en (o1[6]), .exmem_en (o1[5]), .memwb_en (o1[4]),
    .ifid_flush (o1[3]), .idex_flush (o1[2]), .exmem_flush (o1[1]), .mul_busy (o1[0])
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles (sc1), .flush_events (fe1)
`endif
  );

  // Monitor: each negedge, the expectation pushed half a cycle earlier is checked.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (o4 !== e.e4) begin
          n_bad++;
          $display("FAIL %s lat4: got %b expected %b", e.nm, o4, e.e4);
        end
        n_cmp++;
        if (o1 !== e.e1) begin
          n_bad++;
          $display("FAIL %s lat1: got %b expected %b", e.nm, o1, e.e1);
        end
      end
    end
  end

  task automatic step(input string nm, input logic rstn, input logic vld, input logic mr,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic mul, input logic rdr,
                      input logic [8:0] e4, input logic [8:0] e1);
    exp_t e;
    @(posedge clk);
    #1;
    arst_n = rstn; id_valid = vld; idex_memread = mr; idex_rd = rd;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    idex_mul = mul; exmem_redirect = rdr;
    e.nm = nm; e.e4 = e4; e.e1 = e1;
    q.push_back(e);
  endtask

  initial begin
    //    name          rst vld mr rd  rs1 u1 rs2 u2 mul rdr  lat4   lat1
    step("reset",       0,  1, 0, 0,  0,  0, 0,  0, 0,  0,   VRst, VRst);
    step("idle",        1,  1, 0, 0,  0,  0, 0,  0, 0,  0,   VRun, VRun);
    step("lu_rs2",      1,  1, 1, 5,  0,  0, 5,  1, 0,  0,   VLu,  VLu);
    step("lu_after",    1,  1, 0, 0,  0,  0, 5,  1, 0,  0,   VRun, VRun);
    step("lu_x0",       1,  1, 1, 0,  0,  0, 0,  1, 0,  0,   VRun, VRun);
    step("lu_nouse",    1,  1, 1, 7,  7,  0, 0,  0, 0,  0,   VRun, VRun);
    step("lu_rs1",      1,  1, 1, 7,  7,  1, 0,  0, 0,  0,   VLu,  VLu);
    step("lu_clear",    1,  1, 0, 0,  7,  1, 0,  0, 0,  0,   VRun, VRun);
    step("mul_enter",   1,  1, 0, 0,  0,  0, 0,  0, 1,  0,   VMul, VRun);
    step("mul_wait2",   1,  1, 0, 0,  0,  0, 0,  0, 1,  0,   VMul, VRun);
    step("mul_wait1",   1,  1, 0, 0,  0,  0, 0,  0, 1,  0,   VMul, VRun);
    step("mul_release", 1,  1, 0, 0,  0,  0, 0,  0, 1,  0,   VRun, VRun);
    step("mul_done",    1,  1, 0, 0,  0,  0, 0,  0, 0,  0,   VRun, VRun);
    step("rdr_mulent",  1,  1, 0, 0,  0,  0, 0,  0, 1,  0,   VMul, VRun);
    step("rdr_in_wait", 1,  1, 0, 0,  0,  0, 0,  0, 1,  1,   VRdr, VRdr);
    step("rdr_after",   1,  1, 0, 0,  0,  0, 0,  0, 0,  0,   VRun, VRun);
    step("rst_mulent",  1,  1, 0, 0,  0,  0, 0,  0, 1,  0,   VMul, VRun);
    step("rst_wait2",   1,  1, 0, 0,  0,  0, 0,  0, 1,  0,   VMul, VRun);
    step("rst_mid_mul", 0,  1, 0, 0,  0,  0, 0,  0, 1,  0,   VRst, VRst);
    step("rst_release", 1,  1, 0, 0,  0,  0, 0,  0, 0,  0,   VRun, VRun);
    step("mul2_enter",  1,  1, 0, 0,  0,  0, 0,  0, 1,  0,   VMul, VRun);
    step("mul2_wait2",  1,  1, 0, 0,  0,  0, 0,  0, 1,  0,   VMul, VRun);
    step("mul2_wait1",  1,  1, 0, 0,  0,  0, 0,  0, 1,  0,   VMul, VRun);
    step("mul2_rel",    1,  1, 0, 0,  0,  0, 0,  0, 1,  0,   VRun, VRun);
    step("mul2_done",   1,  1, 0, 0,  0,  0, 0,  0, 0,  0,   VRun, VRun);
    step("rdr_vs_lu",   1,  1, 1, 5,  0,  0, 5,  1, 0,  1,   VRdr, VRdr);
    step("rdr_lu_aft",  1,  1, 0, 0,  0,  0, 0,  0, 0,  0,   VRun, VRun);
    step("lu_novalid",  1,  0, 1, 5,  5,  1, 5,  1, 0,  0,   VRun, VRun);
    step("final_idle",  1,  1, 0, 0,  0,  0, 0,  0, 0,  0,   VRun, VRun);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end

`ifdef HAZ_PERF_CNT_EN
    // Counters restart at rst_mid_mul; afterwards lat4 sees three stalls and one redirect.
    @(negedge clk);
    n_cmp++;
    if (sc4 !== 32'd3) begin n_bad++; $display("FAIL stall_cycles lat4: got %0d expected 3", sc4); end
    n_cmp++;
    if (fe4 !== 32'd1) begin n_bad++; $display("FAIL flush_events lat4: got %0d expected 1", fe4); end
    n_cmp++;
    if (sc1 !== 32'd0) begin n_bad++; $display("FAIL stall_cycles lat1: got %0d expected 0", sc1); end
    n_cmp++;
    if (fe1 !== 32'd1) begin n_bad++; $display("FAIL flush_events lat1: got %0d expected 1", fe1); end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
